// File: rtl/branch_predict_resolve_if.sv
// Bundle of the fetch-side prediction and execute-side resolve signals
// exchanged between the pipeline and branch_predict_resolve.
//   master : pipeline side (drives PCs, EX branch info, ALU flags)
//   slave  : branch unit side (drives prediction, resolve results, statistics)
// CNT_W sets the width of the statistics counters and must match the unit's CNT_W.
interface branch_predict_resolve_if #(
    parameter int unsigned CNT_W = 16
);
    logic [31:0]      if_pc;
    logic             if_pred_taken;
    logic             ex_valid;
    logic             ex_branch;
    logic [2:0]       ex_funct3;
    logic [31:0]      ex_pc;
    logic             ex_pred_taken;
    logic             zero_flag;
    logic             carry_flag;
    logic             overflow_flag;
    logic             sign_flag;
    logic             br_taken;
    logic             br_mispredict;
    logic             br_illegal;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output if_pc, ex_valid, ex_branch, ex_funct3, ex_pc, ex_pred_taken,
               zero_flag, carry_flag, overflow_flag, sign_flag,
        input  if_pred_taken, br_taken, br_mispredict, br_illegal,
               branch_count, mispred_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_branch, ex_funct3, ex_pc, ex_pred_taken,
               zero_flag, carry_flag, overflow_flag, sign_flag,
        output if_pred_taken, br_taken, br_mispredict, br_illegal,
               branch_count, mispred_count
    );
endinterface

// File: rtl/branch_predict_resolve.sv
// RV32I conditional branch resolve (EX) and bimodal direction prediction (IF).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : branch_predict_resolve_if.slave
//          in : if_pc, ex_valid, ex_branch, ex_funct3, ex_pc, ex_pred_taken,
//               zero/carry/overflow/sign flags of rs1 - rs2
//          out: if_pred_taken (comb.), br_taken/br_mispredict/br_illegal
//               (registered, one cycle after EX), branch_count, mispred_count
// Parameters: IDX_W (table index width), MODE (0 static NT, 1 bimodal),
//             CNT_W (statistics counter width).
module branch_predict_resolve #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned MODE  = 1,
    parameter int unsigned CNT_W = 16
) (
    input logic                     clk,
    input logic                     rst,
    branch_predict_resolve_if.slave bus
);
    localparam int unsigned ENTRIES = 2 ** IDX_W;

    logic [1:0]       table_q [ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    logic res_en;
    logic taken_c;
    logic illegal_c;
    logic mispred_c;

    logic             br_taken_q;
    logic             br_mispredict_q;
    logic             br_illegal_q;
    logic [CNT_W-1:0] branch_count_q;
    logic [CNT_W-1:0] mispred_count_q;

    assign rd_idx = bus.if_pc[IDX_W+1:2];
    assign wr_idx = bus.ex_pc[IDX_W+1:2];
    assign res_en = bus.ex_valid & bus.ex_branch;

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        if (res_en) begin
            unique case (bus.ex_funct3)
                3'b000:  taken_c = bus.zero_flag;
                3'b001:  taken_c = ~bus.zero_flag;
                3'b100:  taken_c = bus.sign_flag ^ bus.overflow_flag;
                3'b101:  taken_c = ~(bus.sign_flag ^ bus.overflow_flag);
                3'b110:  taken_c = ~bus.carry_flag;
                3'b111:  taken_c = bus.carry_flag;
                default: illegal_c = 1'b1;
            endcase
        end
        // Illegal encodings resolve not-taken, so a taken prediction is a mispredict.
        mispred_c = res_en & (taken_c != bus.ex_pred_taken);
    end

    // Combinational read of the pre-edge table: an update on this edge is seen next cycle.
    assign bus.if_pred_taken = (MODE == 1) ? table_q[rd_idx][1] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            table_q         <= '{default: 2'b01};
            br_taken_q      <= 1'b0;
            br_mispredict_q <= 1'b0;
            br_illegal_q    <= 1'b0;
            branch_count_q  <= '0;
            mispred_count_q <= '0;
        end else begin
            br_taken_q      <= taken_c;
            br_mispredict_q <= mispred_c;
            br_illegal_q    <= illegal_c;

            if ((MODE == 1) && res_en && !illegal_c) begin
                if (taken_c && (table_q[wr_idx] != 2'b11))
                    table_q[wr_idx] <= table_q[wr_idx] + 2'b01;
                else if (!taken_c && (table_q[wr_idx] != 2'b00))
                    table_q[wr_idx] <= table_q[wr_idx] - 2'b01;
            end

            if (res_en && (branch_count_q != '1))
                branch_count_q <= branch_count_q + 1'b1;
            if (mispred_c && (mispred_count_q != '1))
                mispred_count_q <= mispred_count_q + 1'b1;
        end
    end

    assign bus.br_taken      = br_taken_q;
    assign bus.br_mispredict = br_mispredict_q;
    assign bus.br_illegal    = br_illegal_q;
    assign bus.branch_count  = branch_count_q;
    assign bus.mispred_count = mispred_count_q;

    // PC bits outside the index field are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0],
                              bus.ex_pc[31:IDX_W+2], bus.ex_pc[1:0]};
endmodule
